mul_unit: RTL and testbench

- Iterative multiply unit for the RV32M multiply subset (MUL, MULH, MULHSU, MULHU).
- Sits in the execute stage beside the ALU. It consumes the same decoded instruction fields and register operands that feed the ALU control path, and returns a 32-bit result to writeback.
- While an operation is in flight it asserts busy so the pipeline holds the instruction in execute.
- Radix-2 shift-add on operand magnitudes, followed by a sign fix-up.

---
 rtl/mul_unit.sv | 148 ++++++++++++++
 tb/tb_mul_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit
// Iterative RV32M multiply unit (MUL, MULH, MULHSU, MULHU) for the execute
// stage. It forms operand magnitudes and runs one radix-2 shift-add step per
// clock. A final fix-up stage negates the 2*XLEN-bit product when the operand
// signs differ and selects the low or high half.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request pulse, sampled only in IDLE or DONE
//   func3   instruction[14:12]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
//   rs1     operand A
//   rs2     operand B
//   busy    high while in CALC or FIX; stall request to the pipeline
//   done    one-cycle pulse, result valid
//   result  product slice, held until the next accepted operation completes
// -----------------------------------------------------------------------------
module mul_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    logic [2:0]          op;
    logic                neg;
    logic [CNT_W-1:0]    cnt;
    logic [XLEN-1:0]     a_mag;
    // Upper half accumulates partial sums; lower half starts as |B| and is
    // shifted out one multiplier bit per step.
    logic [2*XLEN-1:0]   prod;

    // Two's complement magnitude. The most negative value maps onto 2^(XLEN-1),
    // which is representable because the result is treated as unsigned.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic            is_signed);
        if (is_signed && v[XLEN-1])
            return ~v + XLEN'(1);
        return v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_negate(input logic [2*XLEN-1:0] v,
                                                      input logic              en);
        if (en)
            return ~v + (2*XLEN)'(1);
        return v;
    endfunction

    logic               a_signed;
    logic               b_signed;
    logic               sign_a;
    logic               sign_b;
    logic               accept;
    logic [XLEN-1:0]    addend;
    logic [XLEN:0]      step_sum;
    logic [2*XLEN-1:0]  fixed;

    always_comb begin
        a_signed = (func3 == 3'b001) || (func3 == 3'b010);
        b_signed = (func3 == 3'b001);
        sign_a   = a_signed && rs1[XLEN-1];
        sign_b   = b_signed && rs2[XLEN-1];
        accept   = start && ((state == IDLE) || (state == DONE));
        addend   = prod[0] ? a_mag : '0;
        step_sum = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, addend};
        fixed    = cond_negate(prod, neg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op     <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            a_mag  <= '0;
            prod   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else if (accept) begin
            op   <= func3;
            cnt  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
            if (func3[2]) begin
                // Divide encodings are not handled here: bypass the iteration
                // and let FIX emit a zero result.
                a_mag <= '0;
                prod  <= '0;
                neg   <= 1'b0;
                state <= FIX;
            end else begin
                a_mag <= magnitude(rs1, a_signed);
                prod  <= {{XLEN{1'b0}}, magnitude(rs2, b_signed)};
                neg   <= sign_a ^ sign_b;
                state <= CALC;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                end
                CALC: begin
                    prod <= {step_sum, prod[XLEN-1:1]};
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP)
                        state <= FIX;
                end
                FIX: begin
                    if (op == 3'b000)
                        result <= fixed[XLEN-1:0];
                    else
                        result <= fixed[2*XLEN-1:XLEN];
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_unit
// Scoreboard bench for mul_unit: expected results are queued when an operation
// is issued and compared when done pulses. Latency, busy duration, result
// hold, ignored starts, back-to-back starts and asynchronous reset are checked.
// -----------------------------------------------------------------------------
module tb_mul_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      func3 = 3'b000;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    mul_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .func3  (func3),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          spurious = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = '0;
    logic [31:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference product from 64-bit arithmetic on sign/zero-extended operands.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] a64;
        logic [63:0] b64;
        logic [63:0] p;
        a64 = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
        b64 = (f == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
        p   = a64 * b64;
        if (f[2])
            return 32'h0;
        if (f == 3'b000)
            return p[31:0];
        return p[63:32];
    endfunction

    // Result monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                spurious++;
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", result, mon_exp);
                last_res = mon_exp;
            end
        end
    end

    // Drives one start pulse and queues its expected result. Returns just
    // after the accepting edge with operands scrambled, so anything not
    // latched at acceptance would corrupt the product.
    task automatic issue(input bit sync, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        if (sync)
            @(negedge clk);
        func3 = f;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        rs1   = $urandom;
        rs2   = $urandom;
        func3 = 3'($urandom_range(0, 7));
    endtask

    // Counts rising edges until done is seen at a falling edge; also counts
    // falling edges with busy high. Bounded so a stuck DUT cannot hang the run.
    task automatic wait_done(output int edges, output int bcnt);
        edges = 0;
        bcnt  = 0;
        @(negedge clk);
        check("result_held", result, last_res);
        while (!done && edges < 100) begin
            if (busy)
                bcnt++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input int exp_busy);
        int edges;
        int bcnt;
        issue(1'b1, f, a, b, exp);
        wait_done(edges, bcnt);
        check("latency", 32'(edges + 1), 32'(exp_lat));
        check("busy_cycles", 32'(bcnt), 32'(exp_busy));
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int edges;
        int bcnt;
        int d0;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
        vecs[3]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[4]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[5]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[6]  = '{3'b000, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000};
        vecs[7]  = '{3'b001, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000};
        vecs[8]  = '{3'b001, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[9]  = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        vecs[10] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic MUL with full latency
        run(3'b000, 32'd7, 32'd6, 32'h0000_002A, 34, 33);

        // Directed corner products
        foreach (vecs[i])
            run(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, 34, 33);

        // Random products across the four multiply encodings
        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            run(rf, ra, rb, model(rf, ra, rb), 34, 33);
        end

        // Unsupported encodings bypass the iteration
        run(3'b100, 32'd5, 32'd6, 32'h0, 2, 1);
        run(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, model(3'b011, 32'h1234_5678, 32'h9ABC_DEF0), 34, 33);
        run(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 2, 1);

        // Start while busy is ignored; start in the done cycle is accepted
        issue(1'b1, 3'b000, 32'd3, 32'd5, 32'h0000_000F);
        repeat (10) @(posedge clk);
        @(negedge clk);
        func3 = 3'b000;
        rs1   = 32'd9;
        rs2   = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(edges, bcnt);
        check("ignored_start_latency", 32'(edges), 32'd22);
        issue(1'b0, 3'b000, 32'd4, 32'd4, 32'h0000_0010);
        wait_done(edges, bcnt);
        check("b2b_latency", 32'(edges + 1), 32'd34);
        check("b2b_busy_cycles", 32'(bcnt), 32'd33);

        // Asynchronous reset in the middle of CALC
        issue(1'b1, 3'b001, 32'hDEAD_BEEF, 32'h0BAD_F00D, model(3'b001, 32'hDEAD_BEEF, 32'h0BAD_F00D));
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_result", result, 32'h0);
        exp_q.delete();
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
        check("idle_after_reset", 32'(busy), 32'd0);

        // Recovery after reset
        run(3'b010, 32'h8765_4321, 32'h0FED_CBA9, model(3'b010, 32'h8765_4321, 32'h0FED_CBA9), 34, 33);

        repeat (3) @(negedge clk);
        check("spurious_done", 32'(spurious), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
